// File: rtl/pkt_gen_token_sched.sv
// Packet-generator task scheduler: per-flow token buckets refilled every UPDATE_PERIOD clocks,
// one RR/SP grant per cycle, granted {flow, size} tasks queued in a show-ahead FIFO.
module pkt_gen_token_sched #(
   parameter int unsigned FLOW_CNT       = 16,
   parameter int unsigned UPDATE_PERIOD  = 100,
   parameter int unsigned SIZE_WIDTH     = 16,
   parameter int unsigned TOKEN_WIDTH    = 32,
   parameter int unsigned FIFO_AWIDTH    = 4,
   localparam int unsigned FLOW_CNT_WIDTH = (FLOW_CNT == 1) ? 1 : $clog2(FLOW_CNT)
)(
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic [FLOW_CNT_WIDTH-1:0] wr_size_addr_i,
   input  logic [SIZE_WIDTH-1:0]     wr_size_data_i,
   input  logic                      wr_size_wr_en_i,
   input  logic [FLOW_CNT_WIDTH-1:0] wr_token_addr_i,
   input  logic [TOKEN_WIDTH-1:0]    wr_token_data_i,
   input  logic                      wr_token_wr_en_i,
   input  logic [FLOW_CNT_WIDTH-1:0] wr_flow_en_addr_i,
   input  logic                      wr_flow_en_data_i,
   input  logic                      wr_flow_en_wr_en_i,
   input  logic                      sched_mode_i,
   output logic [FLOW_CNT_WIDTH-1:0] task_flow_num_o,
   output logic [SIZE_WIDTH-1:0]     task_pkt_size_o,
   output logic                      task_valid_o,
   input  logic                      task_ready_i,
   output logic [FIFO_AWIDTH:0]      fifo_usedw_o,
   output logic [31:0]               grant_cnt_o
);

   localparam int unsigned DEPTH  = 1 << FIFO_AWIDTH;
   localparam int unsigned PW     = $clog2(UPDATE_PERIOD);
   localparam int unsigned TASK_W = FLOW_CNT_WIDTH + SIZE_WIDTH;

   logic [SIZE_WIDTH-1:0]     size_r     [FLOW_CNT];
   logic [TOKEN_WIDTH-1:0]    rate_r     [FLOW_CNT];
   logic [TOKEN_WIDTH-1:0]    bucket_r   [FLOW_CNT];
   logic [TOKEN_WIDTH-1:0]    bucket_dec [FLOW_CNT];
   logic [TOKEN_WIDTH:0]      bucket_sum [FLOW_CNT];
   logic [TOKEN_WIDTH-1:0]    bucket_nxt [FLOW_CNT];
   logic [FLOW_CNT-1:0]       en_r;
   logic [FLOW_CNT-1:0]       elig;

   logic [PW-1:0]             period_cnt;
   logic                      tick;
   logic [FLOW_CNT_WIDTH-1:0] rr_ptr;
   logic [FLOW_CNT_WIDTH-1:0] rr_cand;
   logic [FLOW_CNT_WIDTH-1:0] rr_idx;
   logic [FLOW_CNT_WIDTH-1:0] sp_idx;
   logic [FLOW_CNT_WIDTH-1:0] grant_idx;
   logic                      grant;

   logic [TASK_W-1:0]         fifo_mem [DEPTH];
   logic [FIFO_AWIDTH-1:0]    wr_ptr;
   logic [FIFO_AWIDTH-1:0]    rd_ptr;
   logic [FIFO_AWIDTH:0]      usedw;
   logic                      fifo_full;
   logic                      fifo_empty;
   logic                      push;
   logic                      pop;

   assign tick = (period_cnt == PW'(UPDATE_PERIOD - 1));

   always_comb begin
      for (int unsigned i = 0; i < FLOW_CNT; i++) begin
         elig[i] = en_r[i] && (size_r[i] != '0) && (bucket_r[i] >= TOKEN_WIDTH'(size_r[i]));
      end
   end

   // Both scans run downward so the last hit is the winner: lowest index for SP,
   // nearest index after the pointer for RR.
   always_comb begin
      sp_idx  = '0;
      rr_idx  = '0;
      rr_cand = '0;
      for (int unsigned i = FLOW_CNT; i > 0; i--) begin
         if (elig[i-1]) sp_idx = FLOW_CNT_WIDTH'(i - 1);
      end
      for (int unsigned k = FLOW_CNT; k > 0; k--) begin
         rr_cand = FLOW_CNT_WIDTH'((32'(rr_ptr) + k) % FLOW_CNT);
         if (elig[rr_cand]) rr_idx = rr_cand;
      end
   end

   assign fifo_full  = usedw[FIFO_AWIDTH];
   assign fifo_empty = (usedw == '0);
   assign grant      = (|elig) && !fifo_full;
   assign grant_idx  = sched_mode_i ? sp_idx : rr_idx;
   assign push       = grant;
   assign pop        = !fifo_empty && task_ready_i;

   always_comb begin
      for (int unsigned i = 0; i < FLOW_CNT; i++) begin
         bucket_dec[i] = (grant && (grant_idx == FLOW_CNT_WIDTH'(i)))
                         ? bucket_r[i] - TOKEN_WIDTH'(size_r[i]) : bucket_r[i];
         bucket_sum[i] = {1'b0, bucket_dec[i]} + {1'b0, rate_r[i]};
         if (tick && en_r[i])
            bucket_nxt[i] = bucket_sum[i][TOKEN_WIDTH] ? '1 : bucket_sum[i][TOKEN_WIDTH-1:0];
         else
            bucket_nxt[i] = bucket_dec[i];
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int unsigned i = 0; i < FLOW_CNT; i++) begin
            size_r[i]   <= '0;
            rate_r[i]   <= '0;
            bucket_r[i] <= '0;
         end
         en_r <= '0;
      end else begin
         if (wr_size_wr_en_i)    size_r[wr_size_addr_i]  <= wr_size_data_i;
         if (wr_token_wr_en_i)   rate_r[wr_token_addr_i] <= wr_token_data_i;
         if (wr_flow_en_wr_en_i) en_r[wr_flow_en_addr_i] <= wr_flow_en_data_i;
         for (int unsigned i = 0; i < FLOW_CNT; i++) begin
            if (wr_flow_en_wr_en_i && !wr_flow_en_data_i &&
                (wr_flow_en_addr_i == FLOW_CNT_WIDTH'(i)))
               bucket_r[i] <= '0;
            else
               bucket_r[i] <= bucket_nxt[i];
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         period_cnt  <= '0;
         rr_ptr      <= FLOW_CNT_WIDTH'(FLOW_CNT - 1);
         grant_cnt_o <= '0;
      end else begin
         period_cnt <= tick ? '0 : period_cnt + 1'b1;
         if (grant) begin
            grant_cnt_o <= grant_cnt_o + 32'd1;
            if (!sched_mode_i) rr_ptr <= grant_idx;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (push) fifo_mem[wr_ptr] <= {grant_idx, size_r[grant_idx]};
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         usedw  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   usedw <= usedw + 1'b1;
            2'b01:   usedw <= usedw - 1'b1;
            default: usedw <= usedw;
         endcase
      end
   end

   // Head is masked while empty so the outputs read zero after reset and after draining.
   assign task_valid_o    = !fifo_empty;
   assign task_flow_num_o = fifo_empty ? '0 : fifo_mem[rd_ptr][TASK_W-1:SIZE_WIDTH];
   assign task_pkt_size_o = fifo_empty ? '0 : fifo_mem[rd_ptr][SIZE_WIDTH-1:0];
   assign fifo_usedw_o    = usedw;

endmodule

// File: tb/tb_pkt_gen_token_sched.sv
// Directed bench for pkt_gen_token_sched; cycle numbers count clock edges after reset release.
module tb_pkt_gen_token_sched;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  wr_size_addr = '0;
   logic [15:0] wr_size_data = '0;
   logic        wr_size_wr_en = 1'b0;
   logic [3:0]  wr_token_addr = '0;
   logic [31:0] wr_token_data = '0;
   logic        wr_token_wr_en = 1'b0;
   logic [3:0]  wr_flow_en_addr = '0;
   logic        wr_flow_en_data = 1'b0;
   logic        wr_flow_en_wr_en = 1'b0;
   logic        sched_mode = 1'b0;
   logic [3:0]  task_flow_num;
   logic [15:0] task_pkt_size;
   logic        task_valid;
   logic        task_ready = 1'b0;
   logic [4:0]  fifo_usedw;
   logic [31:0] grant_cnt;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;
   int seen = 0;

   pkt_gen_token_sched #(
      .FLOW_CNT(16), .UPDATE_PERIOD(100), .SIZE_WIDTH(16), .TOKEN_WIDTH(32), .FIFO_AWIDTH(4)
   ) dut (
      .clk_i(clk), .rst_i(rst),
      .wr_size_addr_i(wr_size_addr), .wr_size_data_i(wr_size_data), .wr_size_wr_en_i(wr_size_wr_en),
      .wr_token_addr_i(wr_token_addr), .wr_token_data_i(wr_token_data), .wr_token_wr_en_i(wr_token_wr_en),
      .wr_flow_en_addr_i(wr_flow_en_addr), .wr_flow_en_data_i(wr_flow_en_data),
      .wr_flow_en_wr_en_i(wr_flow_en_wr_en), .sched_mode_i(sched_mode),
      .task_flow_num_o(task_flow_num), .task_pkt_size_o(task_pkt_size), .task_valid_o(task_valid),
      .task_ready_i(task_ready), .fifo_usedw_o(fifo_usedw), .grant_cnt_o(grant_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic run_to(input int n);
      while (cyc < n) step();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      wr_size_wr_en = 1'b0;
      wr_token_wr_en = 1'b0;
      wr_flow_en_wr_en = 1'b0;
      task_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      cyc = 0;
   endtask

   task automatic cfg(input logic [3:0] flow, input logic [15:0] size, input logic [31:0] rate,
                      input logic en);
      wr_size_addr = flow;    wr_size_data = size;    wr_size_wr_en = 1'b1;
      wr_token_addr = flow;   wr_token_data = rate;   wr_token_wr_en = 1'b1;
      wr_flow_en_addr = flow; wr_flow_en_data = en;   wr_flow_en_wr_en = 1'b1;
      step();
      wr_size_wr_en = 1'b0;
      wr_token_wr_en = 1'b0;
      wr_flow_en_wr_en = 1'b0;
   endtask

   task automatic burst(input logic mode, input string tag);
      do_reset();
      sched_mode = mode;
      task_ready = 1'b1;
      for (int f = 0; f < 3; f++) cfg(4'(f), 16'd64, 32'd640, 1'b1);
      run_to(100);
      chk({tag, "_pre_valid"}, 32'(task_valid), 32'd0);
      for (int k = 0; k < 30; k++) begin
         step();
         chk({tag, "_valid"}, 32'(task_valid), 32'd1);
         chk({tag, "_flow"}, 32'(task_flow_num), mode ? 32'(k / 10) : 32'(k % 3));
         chk({tag, "_size"}, 32'(task_pkt_size), 32'd64);
      end
      step();
      chk({tag, "_post_valid"}, 32'(task_valid), 32'd0);
      chk({tag, "_grants"}, grant_cnt, 32'd30);
   endtask

   initial begin
      // reset state
      do_reset();
      chk("rst_valid", 32'(task_valid), 32'd0);
      chk("rst_flow", 32'(task_flow_num), 32'd0);
      chk("rst_size", 32'(task_pkt_size), 32'd0);
      chk("rst_usedw", 32'(fifo_usedw), 32'd0);
      chk("rst_grants", grant_cnt, 32'd0);

      // 1: single flow, one task per refill period
      task_ready = 1'b1;
      cfg(4'd0, 16'd64, 32'd64, 1'b1);
      seen = 0;
      while (cyc < 1001) begin
         step();
         if (task_valid) begin
            seen++;
            chk("t1_flow", 32'(task_flow_num), 32'd0);
            chk("t1_size", 32'(task_pkt_size), 32'd64);
            chk("t1_cycle", 32'(cyc), 32'(101 + 100 * (seen - 1)));
         end
      end
      chk("t1_count", 32'(seen), 32'd10);
      chk("t1_grants", grant_cnt, 32'd10);

      // 2/3: three flows, round-robin then strict priority
      burst(1'b0, "t2_rr");
      burst(1'b1, "t3_sp");

      // 4: FIFO fills with ready low, then drains while grants resume
      do_reset();
      sched_mode = 1'b0;
      cfg(4'd0, 16'd1, 32'd100, 1'b1);
      run_to(108);
      chk("t4_usedw_8", 32'(fifo_usedw), 32'd8);
      chk("t4_grants_8", grant_cnt, 32'd8);
      run_to(120);
      chk("t4_usedw_full", 32'(fifo_usedw), 32'd16);
      chk("t4_grants_full", grant_cnt, 32'd16);
      chk("t4_head_flow", 32'(task_flow_num), 32'd0);
      chk("t4_head_size", 32'(task_pkt_size), 32'd1);
      task_ready = 1'b1;
      step();
      chk("t4_pop_no_grant_usedw", 32'(fifo_usedw), 32'd15);
      chk("t4_pop_no_grant_cnt", grant_cnt, 32'd16);
      run_to(130);
      chk("t4_resume_grants", grant_cnt, 32'd25);
      chk("t4_resume_usedw", 32'(fifo_usedw), 32'd15);
      run_to(199);
      chk("t4_grants_199", grant_cnt, 32'd94);

      // 5: size 0 never eligible; saturated bucket then grants every cycle
      do_reset();
      task_ready = 1'b1;
      cfg(4'd3, 16'd0, 32'hFFFF_FFFF, 1'b1);
      run_to(350);
      chk("t5_size0_valid", 32'(task_valid), 32'd0);
      chk("t5_size0_grants", grant_cnt, 32'd0);
      cfg(4'd3, 16'd1, 32'hFFFF_FFFF, 1'b1);
      chk("t5_write_edge_valid", 32'(task_valid), 32'd0);
      step();
      chk("t5_first_valid", 32'(task_valid), 32'd1);
      chk("t5_first_flow", 32'(task_flow_num), 32'd3);
      chk("t5_first_size", 32'(task_pkt_size), 32'd1);
      run_to(360);
      chk("t5_grants_360", grant_cnt, 32'd9);
      run_to(410);
      chk("t5_grants_410", grant_cnt, 32'd59);

      // 6: disable mid-burst clears bucket; queued tasks drain; async reset
      do_reset();
      cfg(4'd0, 16'd1, 32'd100, 1'b1);
      run_to(118);
      cfg(4'd0, 16'd1, 32'd100, 1'b0);
      task_ready = 1'b1;
      run_to(125);
      chk("t6_drain_valid", 32'(task_valid), 32'd1);
      chk("t6_drain_flow", 32'(task_flow_num), 32'd0);
      run_to(140);
      chk("t6_empty_valid", 32'(task_valid), 32'd0);
      chk("t6_empty_usedw", 32'(fifo_usedw), 32'd0);
      chk("t6_no_new_grants", grant_cnt, 32'd16);
      cfg(4'd0, 16'd1, 32'd100, 1'b1);
      run_to(199);
      chk("t6_bucket_cleared", grant_cnt, 32'd16);
      run_to(205);
      chk("t6_refilled_grants", grant_cnt, 32'd21);
      chk("t6_refilled_valid", 32'(task_valid), 32'd1);
      #2;
      rst = 1'b1;
      #1;
      chk("t6_async_valid", 32'(task_valid), 32'd0);
      chk("t6_async_grants", grant_cnt, 32'd0);
      chk("t6_async_usedw", 32'(fifo_usedw), 32'd0);
      chk("t6_async_flow", 32'(task_flow_num), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
